if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//   Instruction-fetch front end; producer side of the IF/ID pipeline register.
//   Holds the fetch PC and issues one-outstanding requests to instruction memory.
//   Presents {PC, instruction, valid} to decode/IF_ID and drives IF_ID's bubble input.
//   Redirects, such as taken branches or jumps, squash in-flight fetches by dropping stale responses.
// PARAMETERS
//   RESET_PC   32'h00000000  fetch PC loaded on reset
//   PC_STEP    4             PC increment per accepted request (bytes)
// PORTS
//   clk            in   1   clock; all state updates on posedge
//   rst            in   1   synchronous, active-high reset
//   stall_in       in   1   hazard unit: hold current fetch output, do not consume
//   redirect_valid in   1   branch/jump resolved: restart fetch at redirect_pc
//   redirect_pc    in   32  new fetch address
//   imem_req_valid out  1   request valid
//   imem_req_ready in   1   memory accepts request
//   imem_req_addr  out  32  request address (= fetch_pc)
//   imem_rsp_valid in   1   response valid; one cycle pulse; no backpressure
//   imem_rsp_data  in   32  instruction word
//   instr_valid    out  1   instr_out/PC_out hold a live instruction
//   instr_out      out  32  fetched instruction
//   PC_out         out  32  address of instr_out
//   bubble_out     out  1   = ~instr_valid; drives IF_ID bubble
// BEHAVIOUR
//   Reset: fetch_pc=RESET_PC, state=REQ, drop=0, instr_valid=0, instr_out=0, PC_out=0.
//     Memory shares rst, so no responses arrive after reset; reset mid-WAIT simply abandons the request.
//   FSM states: REQ (may issue), WAIT (one request outstanding).
//   imem_req_valid = (state==REQ) & ~(instr_valid & stall_in); combinational from registers/stall_in.
//   REQ: req_valid & req_ready -> fetch_pc+=PC_STEP, req_pc<=fetch_pc, state=WAIT.
//   WAIT: rsp_valid & ~drop -> instr_out<=rsp_data, PC_out<=req_pc, instr_valid<=1, state=REQ.
//         rsp_valid & drop  -> discard data, drop<=0, state=REQ.
//   Consume: instr_valid & ~stall_in at an edge = decode took it; instr_valid<=0 unless new capture same edge.
//   Invariant: a capture never occurs while instr_valid & stall_in, because no request is issued in that condition.
//   Redirect (priority over stall and capture), at the edge:
//     fetch_pc<=redirect_pc; instr_valid<=0.
//     REQ, no handshake: stay REQ.
//     REQ with handshake this edge: state=WAIT, drop<=1 (stale request in flight).
//     WAIT, no rsp: stay WAIT, drop<=1.
//     WAIT, rsp this edge: discard rsp, state=REQ, drop<=0.
//   Redirect while drop already 1: fetch_pc updates; drop stays 1.
//   Latency: accepted request -> instr_valid high the edge after rsp_valid; 0-wait memory gives 1 instr/2 cycles.
//   PC arithmetic is modulo 2^32; no alignment check (0xFFFFFFFC + 4 = 0x00000000).
// STRUCTURE
//   Shared package: fetch_state_t {REQ, WAIT}; constants XLEN=32, INSTR_W=32, default RESET_PC.
//   Single flat module; no sub-module (PC incrementer and FSM are too small to split).
// TESTING
//   1 Reset then ready=1, rsp one cycle after accept with 0x00000013 -> addr 0x0 issued, instr_valid=1, PC_out=0x0, next addr 0x4.
//   2 instr_valid=1, stall_in=1 for 3 cycles -> req_valid=0, outputs frozen, bubble_out=0; stall_in=0 -> next req issued.
//   3 Redirect to 0x100 while WAIT; rsp 0xDEADBEEF arrives 2 cycles later -> rsp discarded, instr_valid stays 0, next addr 0x100.
//   4 Redirect to 0x200 on same edge as rsp_valid -> rsp dropped, no drop flag left set, next addr 0x200, its rsp captured with PC_out=0x200.
//   5 Redirect on same edge as request handshake at 0x8 -> that rsp dropped; fetch resumes at redirect_pc.
//   6 rst asserted mid-WAIT with instr_valid=1 -> all outputs 0, bubble_out=1, next request addr RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Provides data widths, the default reset PC and the fetch FSM state encoding.
package if_fetch_unit_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;

    // Fetch FSM: REQ may issue a request, WAIT has one request outstanding.
    typedef logic [0:0] fetch_state_t;
    localparam fetch_state_t REQ  = 1'b0;
    localparam fetch_state_t WAIT = 1'b1;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between fetch and imem.
// master (fetch): drives req_valid/req_addr; slave (memory): drives req_ready, rsp_valid, rsp_data.
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic [XLEN-1:0]    req_addr;
    logic               rsp_valid;
    logic [INSTR_W-1:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: holds the fetch PC, issues one-outstanding imem requests,
// and presents {PC_out, instr_out, instr_valid} to decode; redirects squash in-flight fetches.
// Ports: clk, rst (sync, active-high), stall_in, redirect_valid/redirect_pc,
//        imem (bus master), instr_valid, instr_out, PC_out, bubble_out (= ~instr_valid).
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [XLEN-1:0] PC_STEP  = 32'd4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_in,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    if_fetch_unit_if.master    imem,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [XLEN-1:0]    PC_out,
    output logic               bubble_out
);

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            drop;

    logic req_fire;
    logic rsp_fire;
    logic consume;

    // Never request while a held instruction is stalled, so a capture
    // can never overwrite an instruction decode has not taken yet.
    assign imem.req_valid = (state == REQ) & ~(instr_valid & stall_in);
    assign imem.req_addr  = fetch_pc;

    assign req_fire   = imem.req_valid & imem.req_ready;
    assign rsp_fire   = (state == WAIT) & imem.rsp_valid;
    assign consume    = instr_valid & ~stall_in;
    assign bubble_out = ~instr_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= REQ;
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            drop        <= 1'b0;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            PC_out      <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_pc;
            instr_valid <= 1'b0;
            if (req_fire) begin
                // Request leaves this edge but targets the old path.
                state  <= WAIT;
                req_pc <= fetch_pc;
                drop   <= 1'b1;
            end else if (rsp_fire) begin
                state <= REQ;
                drop  <= 1'b0;
            end else if (state == WAIT) begin
                drop <= 1'b1;
            end
        end else begin
            if (consume) begin
                instr_valid <= 1'b0;
            end
            if (req_fire) begin
                fetch_pc <= fetch_pc + PC_STEP;
                req_pc   <= fetch_pc;
                state    <= WAIT;
            end
            if (rsp_fire) begin
                state <= REQ;
                if (drop) begin
                    drop <= 1'b0;
                end else begin
                    instr_out   <= imem.rsp_data;
                    PC_out      <= req_pc;
                    instr_valid <= 1'b1;
                end
            end
        end
    end

endmodule
